// File: rtl/layer_0_pkg.sv
// Shared types and constants for the layer-0 input streamer.
// GRID/TOTAL describe the default 416x416 frame with a one-pixel zero border.
package layer_0_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  function automatic int unsigned grid_size(input int unsigned img, input int unsigned pad);
    return img + 2 * pad;
  endfunction

  localparam int unsigned IMG_SIZE_DEF = 416;
  localparam int unsigned PAD_DEF      = 1;
  localparam int unsigned GRID         = grid_size(IMG_SIZE_DEF, PAD_DEF);
  localparam int unsigned TOTAL        = GRID * GRID;

  localparam int unsigned CH0_LSB = 0;
  localparam int unsigned CH1_LSB = 32;
  localparam int unsigned CH2_LSB = 64;

endpackage

// File: rtl/layer_0_raster_counter.sv
// Row/column raster walk over the padded grid with an interior flag and a
// read address that advances only on interior positions.
module layer_0_raster_counter
  import layer_0_pkg::*;
#(
  parameter int unsigned IMG_SIZE   = 416,
  parameter int unsigned PAD        = 1,
  parameter int unsigned ADDR_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  advance,
  output logic                  interior,
  output logic                  last_pos,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam int unsigned G  = grid_size(IMG_SIZE, PAD);
  localparam int unsigned CW = $clog2(G + 1);

  localparam logic [CW-1:0]         G_LAST    = CW'(G - 1);
  localparam logic [CW-1:0]         PAD_C     = CW'(PAD);
  localparam logic [CW-1:0]         IMG_C     = CW'(IMG_SIZE);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(IMG_SIZE * IMG_SIZE - 1);

  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [CW-1:0] row_off;
  logic [CW-1:0] col_off;

  // Offsets below PAD wrap to a large value, so one unsigned compare covers both bounds.
  always_comb begin
    row_off  = row - PAD_C;
    col_off  = col - PAD_C;
    interior = (row_off < IMG_C) && (col_off < IMG_C);
    last_pos = (row == G_LAST) && (col == G_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (clear) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (advance) begin
      if (col == G_LAST) begin
        col <= '0;
        row <= (row == G_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      // Address saturates on the last interior pixel and holds until the next clear.
      if (interior && (addr != ADDR_LAST)) begin
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_0_input_streamer.sv
// Streams a stored 3-channel fp32 image in raster order, optionally framed by a
// zero border, with a fixed two-cycle issue-to-valid latency.
module layer_0_input_streamer
  import layer_0_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DATA_IN_WIDTH = 96,
  parameter int unsigned IMG_SIZE      = 416,
  parameter int unsigned PAD           = 1,
  parameter int unsigned ADDR_WIDTH    = 18
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     start,
  input  logic                     enable,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic [DATA_IN_WIDTH-1:0] mem_data,
  output logic [DATA_IN_WIDTH-1:0] data_out,
  output logic                     valid_out,
  output logic                     busy,
  output logic                     done
);

  state_t state;
  state_t state_nxt;

  logic clear;
  logic issue;
  logic interior;
  logic last_pos;

  logic s1_valid;
  logic s1_zero;
  logic s1_last;
  logic [DATA_IN_WIDTH-1:0] pix;

  layer_0_raster_counter #(
    .IMG_SIZE  (IMG_SIZE),
    .PAD       (PAD),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_counter (
    .clk     (Clk),
    .rst     (Rst),
    .clear   (clear),
    .advance (issue),
    .interior(interior),
    .last_pos(last_pos),
    .addr    (mem_addr)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = STREAM;
          clear     = 1'b1;
        end
      end
      STREAM: begin
        if (enable) begin
          issue = 1'b1;
          if (last_pos) state_nxt = DRAIN;
        end
      end
      // done rises with the final valid_out, so the pipeline is empty after this cycle.
      DRAIN: begin
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy      = (state != IDLE);
    mem_rd_en = issue && interior;
  end

  always_comb begin
    pix = '0;
    if (!s1_zero) begin
      for (int unsigned ch = 0; ch < 3; ch++) begin
        pix[ch*DATA_WIDTH +: DATA_WIDTH] = mem_data[ch*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s1_valid  <= 1'b0;
      s1_zero   <= 1'b0;
      s1_last   <= 1'b0;
      valid_out <= 1'b0;
      done      <= 1'b0;
      data_out  <= '0;
    end else begin
      s1_valid  <= issue;
      s1_zero   <= issue && !interior;
      s1_last   <= issue && last_pos;
      valid_out <= s1_valid;
      done      <= s1_valid && s1_last;
      if (s1_valid) data_out <= pix;
    end
  end

endmodule

// File: doc/layer_0_input_streamer.md
Name: layer_0_input_streamer

Overview:
- Producer end of the layer-0 pixel stream. Reads a stored 3-channel fp32 input image from a synchronous-read RAM and emits packed 96-bit pixels in raster order on data_out/valid_out.
- The stream drives data_in/valid_in of the layer_0 featuremap blocks.
- Optionally inserts a zero border so that the downstream 3x3 convolutions see a padded image.

Parameters:
- DATA_WIDTH, 32, width of one fp32 channel sample.
- DATA_IN_WIDTH, 96, packed pixel width (3 x DATA_WIDTH). Bits [31:0] are ch0, [63:32] ch1, [95:64] ch2.
- IMG_SIZE, 416, image height and width in pixels.
- PAD, 1, zero-border width in pixels. Legal values are 0 and 1.
- ADDR_WIDTH, 18, RAM address width. Must satisfy 2^ADDR_WIDTH >= IMG_SIZE*IMG_SIZE.

Ports:
- Clk  in  1  clock
- Rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to stream a full frame
- enable  in  1  issue enable; low freezes issue of new positions
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  ADDR_WIDTH  RAM pixel address
- mem_data  in  DATA_IN_WIDTH  RAM read data, valid the cycle after mem_rd_en
- data_out  out  DATA_IN_WIDTH  packed pixel to the featuremap blocks
- valid_out  out  1  data_out is valid this cycle
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse marking the end of the frame

Behaviour:
- Reset: all outputs are 0, the state is IDLE, and the counters and pipeline are cleared. Reset asserted mid-frame aborts the frame immediately. No done pulse is produced for an aborted frame.
- Grid:
  - GRID = IMG_SIZE + 2*PAD.
  - Positions (r, c) run from 0 to GRID-1, row-major, c fastest.
  - A position is interior when PAD <= r < IMG_SIZE+PAD and PAD <= c < IMG_SIZE+PAD. All other positions are border.
- FSM states and transitions:
  - IDLE: start=1 -> STREAM. Counters are cleared and busy goes to 1 on the same edge.
  - STREAM: each cycle with enable=1, the current position is issued and the counters advance. When the final position (GRID-1, GRID-1) is issued -> DRAIN.
  - DRAIN: waits for the 2-stage pipeline to empty, then -> IDLE.
  - start is ignored while busy=1.
- Issue, for a position issued in cycle N:
  - Interior position: mem_rd_en=1 in cycle N, with mem_addr holding the current read address.
  - Border position: mem_rd_en=0, and a zero tag enters the pipeline.
  - mem_addr is an incrementing counter starting at 0. It advances only on interior issues and never uses a multiply.
- Pipeline and latency:
  - Stage 1 (cycle N+1) captures the valid and zero tags; mem_data arrives in this cycle.
  - Stage 2 registers data_out in cycle N+2. data_out = zero tag ? 0 : mem_data.
  - valid_out=1 in cycle N+2 for every issued position.
  - Fixed latency: position issue to valid_out is 2 cycles.
  - With enable held high, a frame produces exactly GRID*GRID consecutive valid_out cycles. The first valid_out occurs 3 cycles after the start edge.
- enable=0:
  - No issue, and the counters hold.
  - Positions already in flight still emit, so valid_out may stay high for up to 2 cycles after enable falls.
  - valid_out=0 during the remaining stall cycles. data_out holds its last value.
  - No data is lost or duplicated.
- done: asserted in the same cycle as the final valid_out. busy drops to 0 in the following cycle.
- Back-to-back frames: start in the cycle after done is accepted only once busy=0. It is ignored while busy=1.
- Wrap-around:
  - The column counter wraps GRID-1 -> 0 and increments the row counter at the same time.
  - The counters never exceed GRID-1.
  - mem_addr reaches IMG_SIZE^2-1 on the last interior issue and holds that value until the next start.
- Simultaneous start and Rst: Rst wins.

Decomposition:
- Shared package layer_0_pkg:
  - state enum {IDLE, STREAM, DRAIN}
  - localparam GRID
  - localparam TOTAL = GRID*GRID
  - channel slice offsets CH0_LSB=0, CH1_LSB=32, CH2_LSB=64
- Sub-module layer_0_raster_counter. It holds the row/column counters, the interior flag, the mem_addr increment, and a last_pos flag. Its inputs are clear and advance.
- The top level holds the FSM, the 2-stage pipeline and done generation.

Test Plan:
1. IMG_SIZE=4, PAD=0; RAM[i] = {i+200, i+100, i} per channel. Pulse start with enable=1 -> first valid_out 3 cycles after start. Then 16 consecutive outputs equal to RAM[0..15] in order. done coincides with the 16th output.
2. IMG_SIZE=4, PAD=1 -> 36 outputs. Outputs 0-6 are 0; output 7 = RAM[0]; outputs 7-10 = RAM[0..3]; outputs 11-12 are 0; output 13 = RAM[4]. Outputs 29-35 are 0. mem_rd_en is asserted exactly 16 times.
3. IMG_SIZE=4, PAD=0; drop enable for 5 cycles after the 6th issue -> at most 2 trailing valid_out cycles, then none until enable returns. The sequence is still RAM[0..15] with no gaps in content. Total outputs = 16.
4. Assert Rst for 1 cycle midway through a frame -> all outputs are 0 asynchronously and busy=0. No done pulse. A new start replays from RAM[0].
5. Pulse start again while busy=1 -> ignored, and the output count stays at 16. Pulse start the cycle after busy falls -> a second full frame, identical to the first.
